// File: rtl/bram_fifo_ctrl_if.sv
// bram_fifo_ctrl_if: producer and consumer valid/ready streams of the BRAM FIFO
interface bram_fifo_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_vld;
  logic              in_rdy;
  logic [WORD_W-1:0] in_dat;
  logic              out_vld;
  logic              out_rdy;
  logic [WORD_W-1:0] out_dat;
  modport master (output in_vld, in_dat, out_rdy, input in_rdy, out_vld, out_dat);
  modport slave (input in_vld, in_dat, out_rdy, output in_rdy, out_vld, out_dat);
endinterface

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: dual-port BRAM driven as a valid/ready FIFO with a 2-entry output skid buffer
module bram_fifo_ctrl #(
  parameter int WORD_W = 8,
  parameter int WORDS_N = 256,
  localparam int ADDR_W = $clog2(WORDS_N),
  localparam int CNT_W = $clog2(WORDS_N + 3)
) (
  input  logic              clk,
  input  logic              rst,
  bram_fifo_ctrl_if.slave   io,
  output logic [CNT_W-1:0]  occ,
  output logic              bram_cea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [WORD_W-1:0] bram_dina,
  output logic              bram_rnwa,
  output logic              bram_ceb,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_rnwb,
  input  logic [WORD_W-1:0] bram_doutb
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS_N - 1);
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  bram_cnt;
  logic              inflight;
  logic [1:0]        skid_cnt;
  logic [WORD_W-1:0] skid_tail;
  logic              push;
  logic              pop;
  logic              issue;
  logic              slot;
  // A pop frees a skid slot this cycle, so a read may be issued against it
  // immediately; that keeps streaming at one word per cycle.
  always_comb begin
    io.in_rdy = !rst && bram_cnt != FULL;
    io.out_vld = skid_cnt != 2'd0;
    push = io.in_vld && io.in_rdy;
    pop = io.out_vld && io.out_rdy;
    issue = !rst && bram_cnt != '0 && ({1'b0, skid_cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    slot = 2'(skid_cnt - {1'b0, pop}) == 2'd1;
    occ = bram_cnt + CNT_W'(inflight) + CNT_W'(skid_cnt);
    bram_cea = push;
    bram_addra = wr_ptr;
    bram_dina = io.in_dat;
    bram_rnwa = 1'b0;
    bram_ceb = issue;
    bram_addrb = rd_ptr;
    bram_rnwb = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bram_cnt <= '0;
      inflight <= 1'b0;
      skid_cnt <= 2'd0;
      skid_tail <= '0;
      io.out_dat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + ADDR_W'(1);
      if (issue) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + ADDR_W'(1);
      bram_cnt <= bram_cnt + CNT_W'(push) - CNT_W'(issue);
      inflight <= issue;
      skid_cnt <= skid_cnt + 2'(inflight) - 2'(pop);
      if (pop && skid_cnt == 2'd2) io.out_dat <= skid_tail;
      else if (inflight && !slot) io.out_dat <= bram_doutb;
      if (inflight && slot) skid_tail <= bram_doutb;
    end
  end
endmodule
